// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS oscillator control path.
// Seed words are Q3.29 signed: 3 integer bits (including sign) and 29 fraction bits.
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } dds_state_t;

    localparam int          FRAC_BITS    = 29;
    localparam logic [31:0] Q_ONE        = 32'h2000_0000;

    localparam int          DIV_W_DEF    = 16;
    localparam int          RESEED_W_DEF = 24;

endpackage

// File: rtl/dds_rate_div.sv
// Sample-rate divider: issues a registered one-cycle tick every max(div,1) active cycles.
// en/clear describe the coming cycle, so the tick lands exactly in the cycle it belongs to.
module dds_rate_div
    import dds_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             Fg_CLK,
    input  logic             Fg_RESETn,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] last;
    logic             tick_reg;

    // A divide of 0 behaves as divide-by-1.
    always_comb begin
        last = (div == '0) ? '0 : div - DIV_W'(1);
        if (clear || (cnt_reg == last)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (en) begin
            cnt_reg  <= cnt_next;
            tick_reg <= (cnt_next == last);
        end else begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/dds_osc_seq.sv
// Seed/pacing sequencer ahead of the recursive sine oscillator: load pulse, then paced enables.
// Define DDS_RESEED_EN to re-seed the oscillator every cfg_reseed samples.
module dds_osc_seq
    import dds_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int RESEED_W = RESEED_W_DEF
) (
    input  logic                Fg_CLK,
    input  logic                Fg_RESETn,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [31:0]         cfg_init_1,
    input  logic [31:0]         cfg_init_2,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [RESEED_W-1:0] cfg_reseed,
    input  logic                start,
    input  logic                stop,
    output logic [31:0]         init_1,
    output logic [31:0]         init_2,
    output logic                DDSReady,
    output logic                DDSEnable,
    output logic                running,
    output logic [RESEED_W-1:0] sample_cnt
);

    dds_state_t          state_reg, state_next;
    logic                cfg_loaded_reg;
    logic [31:0]         cfg_init_1_reg, cfg_init_2_reg;
    logic [DIV_W-1:0]    cfg_div_reg, act_div_reg;
    logic [RESEED_W-1:0] cfg_reseed_reg;
    logic [31:0]         init_1_reg, init_2_reg;
    logic                cfg_ready_reg, ddsready_reg, running_reg;
    logic                cfg_ready_next, ddsready_next, running_next;
    logic [RESEED_W-1:0] sample_cnt_reg, sample_cnt_next;
    logic                tick, reseed_hit, cfg_take, launch;
    logic                div_clear, div_en;

    assign cfg_take = cfg_valid && cfg_ready_reg;
    assign launch   = (state_reg == IDLE) && (state_next == LOAD);

    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (start && cfg_loaded_reg) state_next = LOAD;
                LOAD:    state_next = RUN;
                RUN:     if (reseed_hit) state_next = LOAD;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready_next  = (state_next == IDLE);
        ddsready_next   = (state_next == LOAD);
        running_next    = (state_next != IDLE);
        sample_cnt_next = sample_cnt_reg;
        if (state_next == LOAD) begin
            sample_cnt_next = '0;
        end else if ((state_reg == RUN) && tick && (sample_cnt_reg != '1)) begin
            sample_cnt_next = sample_cnt_reg + RESEED_W'(1);
        end
    end

    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            cfg_ready_reg  <= 1'b0;
            ddsready_reg   <= 1'b0;
            running_reg    <= 1'b0;
            sample_cnt_reg <= '0;
        end else begin
            cfg_ready_reg  <= cfg_ready_next;
            ddsready_reg   <= ddsready_next;
            running_reg    <= running_next;
            sample_cnt_reg <= sample_cnt_next;
        end
    end

    // The run snapshots the config at launch, so a config written alongside start waits for the next run.
    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            cfg_loaded_reg <= 1'b0;
            cfg_init_1_reg <= '0;
            cfg_init_2_reg <= '0;
            cfg_div_reg    <= '0;
            cfg_reseed_reg <= '0;
            init_1_reg     <= '0;
            init_2_reg     <= '0;
            act_div_reg    <= '0;
        end else begin
            if (cfg_take) begin
                cfg_loaded_reg <= 1'b1;
                cfg_init_1_reg <= cfg_init_1;
                cfg_init_2_reg <= cfg_init_2;
                cfg_div_reg    <= cfg_div;
                cfg_reseed_reg <= cfg_reseed;
            end
            if (launch) begin
                init_1_reg  <= cfg_init_1_reg;
                init_2_reg  <= cfg_init_2_reg;
                act_div_reg <= cfg_div_reg;
            end
        end
    end

`ifdef DDS_RESEED_EN
    logic [RESEED_W-1:0] act_reseed_reg;

    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            act_reseed_reg <= '0;
        end else if (launch) begin
            act_reseed_reg <= cfg_reseed_reg;
        end
    end

    // Enable in flight completes reseed count: sample_cnt + 1 == reseed.
    assign reseed_hit = (state_reg == RUN) && tick && (act_reseed_reg != '0) &&
                        (sample_cnt_reg == act_reseed_reg - RESEED_W'(1));
`else
    logic reseed_unused;
    assign reseed_unused = ^cfg_reseed_reg;
    assign reseed_hit    = 1'b0;
`endif

    assign div_clear = (state_reg != RUN);
    assign div_en    = (state_next == RUN);

    dds_rate_div #(
        .DIV_W(DIV_W)
    ) u_rate_div (
        .Fg_CLK   (Fg_CLK),
        .Fg_RESETn(Fg_RESETn),
        .clear    (div_clear),
        .en       (div_en),
        .div      (act_div_reg),
        .tick     (tick)
    );

    assign cfg_ready  = cfg_ready_reg;
    assign init_1     = init_1_reg;
    assign init_2     = init_2_reg;
    assign DDSReady   = ddsready_reg;
    assign DDSEnable  = tick;
    assign running    = running_reg;
    assign sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_dds_osc_seq.sv
// Scoreboarded bench for dds_osc_seq: expected DDSReady/DDSEnable cycles are queued by the
// stimulus and consumed by a monitor; level outputs are checked directly by the stimulus.
module tb_dds_osc_seq;

    logic        Fg_CLK = 1'b0;
    logic        Fg_RESETn = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_init_1 = '0;
    logic [31:0] cfg_init_2 = '0;
    logic [15:0] cfg_div = '0;
    logic [23:0] cfg_reseed = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] init_1, init_2;
    logic        DDSReady, DDSEnable, running;
    logic [23:0] sample_cnt;

    dds_osc_seq #(.DIV_W(16), .RESEED_W(24)) dut (
        .Fg_CLK    (Fg_CLK),
        .Fg_RESETn (Fg_RESETn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_init_1(cfg_init_1),
        .cfg_init_2(cfg_init_2),
        .cfg_div   (cfg_div),
        .cfg_reseed(cfg_reseed),
        .start     (start),
        .stop      (stop),
        .init_1    (init_1),
        .init_2    (init_2),
        .DDSReady  (DDSReady),
        .DDSEnable (DDSEnable),
        .running   (running),
        .sample_cnt(sample_cnt)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    // Edge counter: at a falling edge, cyc+1 is the number of the cycle being observed.
    int cyc = 0;
    always @(posedge Fg_CLK) cyc <= cyc + 1;

    int rdy_q[$];
    int ena_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc + 1);
        end else begin
            $display("ok   %s = 0x%0h (cycle %0d)", name, act, cyc + 1);
        end
    endtask

    always @(negedge Fg_CLK) begin
        int cur;
        cur = cyc + 1;
        if (Fg_RESETn) begin
            if (DDSReady) begin
                if (rdy_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL ready_unexpected: pulse at cycle %0d, none required", cur);
                end else begin
                    chk("ready_cycle", 64'(cur), 64'(rdy_q.pop_front()));
                end
            end else if (rdy_q.size() != 0 && rdy_q[0] <= cur) begin
                n_cmp++; n_bad++;
                $display("FAIL ready_missing: no pulse, required at cycle %0d", rdy_q.pop_front());
            end
            if (DDSEnable) begin
                if (ena_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL enable_unexpected: pulse at cycle %0d, none required", cur);
                end else begin
                    chk("enable_cycle", 64'(cur), 64'(ena_q.pop_front()));
                end
            end else if (ena_q.size() != 0 && ena_q[0] <= cur) begin
                n_cmp++; n_bad++;
                $display("FAIL enable_missing: no pulse, required at cycle %0d", ena_q.pop_front());
            end
        end
    end

    // Park at the falling edge inside cycle c; inputs driven now are sampled at edge c.
    task automatic at_cycle(input int c);
        while (cyc < c - 1) @(negedge Fg_CLK);
    endtask

    task automatic send_cfg(input logic [31:0] a, input logic [31:0] b,
                            input logic [15:0] d, input logic [23:0] r);
        cfg_init_1 = a; cfg_init_2 = b; cfg_div = d; cfg_reseed = r;
        cfg_valid = 1'b1;
        @(negedge Fg_CLK);
        cfg_valid = 1'b0;
    endtask

    task automatic do_start(output int t);
        start = 1'b1;
        t = cyc + 1;
        @(negedge Fg_CLK);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge Fg_CLK);
        stop = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rdy_q.size() != 0 || ena_q.size() != 0) && n < 100) begin
            @(negedge Fg_CLK);
            n++;
        end
        if (rdy_q.size() != 0 || ena_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d ready / %0d enable pulses outstanding, required 0",
                     rdy_q.size(), ena_q.size());
        end
    endtask

    initial begin
        int t;
        @(negedge Fg_CLK);
        @(negedge Fg_CLK);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'(0));
        chk("rst_running", 64'(running), 64'(0));
        chk("rst_init_2", 64'(init_2), 64'(0));
        chk("rst_sample_cnt", 64'(sample_cnt), 64'(0));
        Fg_RESETn = 1'b1;
        @(negedge Fg_CLK);
        @(negedge Fg_CLK);
        chk("idle_cfg_ready", 64'(cfg_ready), 64'(1));

        // Start with no config loaded: must be ignored.
        do_start(t);
        repeat (5) @(negedge Fg_CLK);
        chk("nocfg_running", 64'(running), 64'(0));

        // div=4: load at t+1, enables every 4 cycles from t+5.
        send_cfg(32'h0000_0000, 32'h3FFF_FFF0, 16'd4, 24'd0);
        do_start(t);
        rdy_q.push_back(t + 1);
        ena_q.push_back(t + 5); ena_q.push_back(t + 9); ena_q.push_back(t + 13);
        at_cycle(t + 2);
        chk("div4_init_1", 64'(init_1), 64'h0);
        chk("div4_init_2", 64'(init_2), 64'h3FFF_FFF0);
        chk("div4_running", 64'(running), 64'(1));
        chk("div4_cfg_ready", 64'(cfg_ready), 64'(0));
        at_cycle(t + 14);
        do_stop();
        chk("stop_running", 64'(running), 64'(0));
        chk("stop_cfg_ready", 64'(cfg_ready), 64'(1));
        repeat (8) @(negedge Fg_CLK);

        // New config alongside start: this run still uses the previous seeds and divider.
        cfg_init_1 = 32'h1234_5678; cfg_init_2 = 32'h1111_1111; cfg_div = 16'd1; cfg_reseed = 24'd0;
        cfg_valid = 1'b1;
        do_start(t);
        cfg_valid = 1'b0;
        rdy_q.push_back(t + 1);
        ena_q.push_back(t + 5); ena_q.push_back(t + 9);
        at_cycle(t + 2);
        chk("restart_init_1", 64'(init_1), 64'h0);
        chk("restart_init_2", 64'(init_2), 64'h3FFF_FFF0);
        at_cycle(t + 10);
        do_stop();
        repeat (4) @(negedge Fg_CLK);

        // div=0 behaves as 1: enable every cycle from t+2.
        send_cfg(32'h0400_0000, 32'h3000_0000, 16'd0, 24'd0);
        do_start(t);
        rdy_q.push_back(t + 1);
        for (int i = 2; i <= 11; i++) ena_q.push_back(t + i);
        at_cycle(t + 6);
        chk("div0_sample_cnt_mid", 64'(sample_cnt), 64'(4));
        at_cycle(t + 11);
        do_stop();
        chk("div0_sample_cnt", 64'(sample_cnt), 64'(10));
        chk("div0_init_1", 64'(init_1), 64'h0400_0000);
        repeat (3) @(negedge Fg_CLK);

        // div=2, reseed=3.
        send_cfg(32'h0000_0000, 32'h3FFF_FFF0, 16'd2, 24'd3);
        do_start(t);
        rdy_q.push_back(t + 1);
`ifdef DDS_RESEED_EN
        rdy_q.push_back(t + 8); rdy_q.push_back(t + 15);
        ena_q.push_back(t + 3); ena_q.push_back(t + 5); ena_q.push_back(t + 7);
        ena_q.push_back(t + 10); ena_q.push_back(t + 12); ena_q.push_back(t + 14);
        ena_q.push_back(t + 17);
`else
        for (int i = 3; i <= 17; i += 2) ena_q.push_back(t + i);
`endif
        at_cycle(t + 18);
        do_stop();
`ifdef DDS_RESEED_EN
        chk("reseed_sample_cnt", 64'(sample_cnt), 64'(1));
`else
        chk("reseed_sample_cnt", 64'(sample_cnt), 64'(8));
`endif
        repeat (3) @(negedge Fg_CLK);

        // Asynchronous reset in the middle of a divide period.
        send_cfg(32'h0000_0000, 32'h3FFF_FFF0, 16'd4, 24'd0);
        do_start(t);
        rdy_q.push_back(t + 1);
        ena_q.push_back(t + 5);
        at_cycle(t + 7);
        #2 Fg_RESETn = 1'b0;
        #1;
        chk("arst_running", 64'(running), 64'(0));
        chk("arst_sample_cnt", 64'(sample_cnt), 64'(0));
        chk("arst_init_2", 64'(init_2), 64'(0));
        chk("arst_enable", 64'(DDSEnable), 64'(0));
        @(negedge Fg_CLK);
        Fg_RESETn = 1'b1;
        @(negedge Fg_CLK);
        do_start(t);
        repeat (6) @(negedge Fg_CLK);
        chk("arst_nocfg_running", 64'(running), 64'(0));
        chk("arst_cfg_ready", 64'(cfg_ready), 64'(1));

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
